// File: rtl/seq_adder_pkg.sv
// Shared definitions for the chunk-serial adder.
//   state_e  : controller states (IDLE, RUN, DONE)
//   MODE_ADD : mode encoding for A + B + IN_Ci
//   MODE_SUB : mode encoding for A - B
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
//   in_valid/in_ready   : operand handshake (mode, A, B, IN_Ci)
//   out_valid/out_ready : result handshake (s, C_o, ovf, zero)
// master = producer/consumer side, slave = the adder.
interface seq_chunk_adder_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             IN_Ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             C_o;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, mode, A, B, IN_Ci, out_ready,
        input  in_ready, out_valid, s, C_o, ovf, zero
    );

    modport slave (
        input  in_valid, mode, A, B, IN_Ci, out_ready,
        output in_ready, out_valid, s, C_o, ovf, zero
    );

endinterface

// File: rtl/chunk_adder.sv
// CHUNK-wide combinational ripple-carry adder.
//   a_i, b_i : operand chunks
//   ci_i     : carry in
//   sum_o    : chunk sum
//   co_o     : carry out of the chunk MSB
//   cmsb_o   : carry into the chunk MSB (for signed overflow)
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             co_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = ci_i;
        for (int k = 0; k < int'(CHUNK); k++) begin
            sum_o[k] = a_i[k] ^ b_i[k] ^ c[k];
            c[k+1]   = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
        end
    end

    assign co_o   = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Chunk-serial adder/subtractor: one CHUNK-wide slice per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous abort back to IDLE, clears results
//   bus   : slave side of seq_chunk_adder_if (operands in, result out)
// Result appears N = WIDTH/CHUNK cycles after the operand handshake and is
// held until out_ready.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    seq_chunk_adder_if.slave bus
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_ch, b_ch, sum;
    logic             ch_co, ch_cmsb;

    assign a_ch = a_q[32'(idx_q) * CHUNK +: CHUNK];
    assign b_ch = b_q[32'(idx_q) * CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (a_ch),
        .b_i    (b_ch),
        .ci_i   (carry_q),
        .sum_o  (sum),
        .co_o   (ch_co),
        .cmsb_o (ch_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtract as A + ~B + 1; IN_Ci only matters when adding.
                    a_d     = bus.A;
                    b_d     = (bus.mode == MODE_SUB) ? ~bus.B : bus.B;
                    carry_d = (bus.mode == MODE_SUB) ? 1'b1 : bus.IN_Ci;
                    idx_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[32'(idx_q) * CHUNK +: CHUNK] = sum;
                carry_d = ch_co;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    co_d    = ch_co;
                    ovf_d   = ch_cmsb ^ ch_co;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d = IDLE;
            idx_d   = '0;
            s_d     = '0;
            carry_d = 1'b0;
            co_d    = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.C_o       = co_q;
    assign bus.ovf       = ovf_q;
    // Gated so zero reads 0 out of reset and outside a delivered result.
    assign bus.zero      = (state_q == DONE) && (s_q == '0);

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;

    typedef struct {
        int          id;
        logic [31:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(32)) bus ();
    seq_chunk_adder_if #(.WIDTH(8))  bus8 ();

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus8)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t exp8_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Scoreboard monitors: pop one expectation per result handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result32", bus.s, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("[TB] op %0d result s=%h", e.id, bus.s);
                chk($sformatf("op%0d_s", e.id), bus.s, e.s);
                chk($sformatf("op%0d_co", e.id), {31'b0, bus.C_o}, {31'b0, e.co});
                chk($sformatf("op%0d_ovf", e.id), {31'b0, bus.ovf}, {31'b0, e.ovf});
                chk($sformatf("op%0d_zero", e.id), {31'b0, bus.zero}, {31'b0, e.zero});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
            if (exp8_q.size() == 0) begin
                chk("unexpected_result8", {24'b0, bus8.s}, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = exp8_q.pop_front();
                chk($sformatf("op8_%0d_s", e.id), {24'b0, bus8.s}, e.s);
                chk($sformatf("op8_%0d_co", e.id), {31'b0, bus8.C_o}, {31'b0, e.co});
                chk($sformatf("op8_%0d_ovf", e.id), {31'b0, bus8.ovf}, {31'b0, e.ovf});
                chk($sformatf("op8_%0d_zero", e.id), {31'b0, bus8.zero}, {31'b0, e.zero});
            end
        end
    end

    // Present one operand set; returns just after the accepting edge.
    task automatic issue(input bit narrow, input logic m, input logic [31:0] a,
                         input logic [31:0] b, input logic ci);
        int n = 0;
        @(negedge clk);
        while (!(narrow ? bus8.in_ready : bus.in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_issue", {31'b0, narrow ? bus8.in_ready : bus.in_ready}, 32'd1);
        if (narrow) begin
            bus8.mode = m; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.IN_Ci = ci;
            bus8.in_valid = 1'b1;
        end else begin
            bus.mode = m; bus.A = a; bus.B = b; bus.IN_Ci = ci;
            bus.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus8.in_valid = 1'b0;
    endtask

    // Count edges from acceptance until out_valid; bounded.
    task automatic wait_valid(input bit narrow, input int lat, input string nm);
        int cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if ((narrow ? bus8.out_valid : bus.out_valid) === 1'b1) break;
        end
        chk(nm, cyc, lat);
    endtask

    task automatic op32(input int id, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic ci, input logic [31:0] es,
                        input logic eco, input logic eovf, input logic ez);
        exp_t e;
        e.id = id; e.s = es; e.co = eco; e.ovf = eovf; e.zero = ez;
        exp_q.push_back(e);
        issue(1'b0, m, a, b, ci);
        wait_valid(1'b0, 4, $sformatf("op%0d_latency", id));
    endtask

    task automatic op8(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic eco, input logic eovf,
                       input logic ez);
        exp_t e;
        e.id = id; e.s = {24'b0, es}; e.co = eco; e.ovf = eovf; e.zero = ez;
        exp8_q.push_back(e);
        issue(1'b1, 1'b0, {24'b0, a}, {24'b0, b}, 1'b0);
        wait_valid(1'b1, 1, $sformatf("op8_%0d_latency", id));
    endtask

    task automatic chk_outs_cleared(input string nm);
        chk({nm, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({nm, "_s"}, bus.s, 32'd0);
        chk({nm, "_co"}, {31'b0, bus.C_o}, 32'd0);
        chk({nm, "_ovf"}, {31'b0, bus.ovf}, 32'd0);
        chk({nm, "_zero"}, {31'b0, bus.zero}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        clr   = 1'b0;
        bus.in_valid = 1'b0; bus.mode = 1'b0; bus.A = '0; bus.B = '0; bus.IN_Ci = 1'b0;
        bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.mode = 1'b0; bus8.A = '0; bus8.B = '0; bus8.IN_Ci = 1'b0;
        bus8.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_outs_cleared("reset");
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic vectors
        op32(1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        op32(2, 1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        op32(3, 1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        op32(4, 1'b0, 32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0);
        op32(5, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        // IN_Ci=0 must be ignored when subtracting
        op32(6, 1'b1, 32'h0000000A, 32'h0000000A, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);

        // Hold result in DONE while inputs wiggle
        @(posedge clk); #1 bus.out_ready = 1'b0;
        op32(7, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 32'hB4B4B4B4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = ~bus.in_valid;
            bus.A = $urandom;
            bus.B = $urandom;
            @(negedge clk);
            chk("hold_s", bus.s, 32'hB4B4B4B4);
            chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("hold_co", {31'b0, bus.C_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("release_out_valid", {31'b0, bus.out_valid}, 32'd0);
        op32(8, 1'b0, 32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset after chunk 1
        issue(1'b0, 1'b0, 32'h12345678, 32'h11111111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs_cleared("midrun_reset");
        chk("midrun_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        op32(9, 1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);

        // clr during RUN
        issue(1'b0, 1'b0, 32'h00000001, 32'h00000002, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_run_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("clr_run_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("clr_run_no_result", {31'b0, bus.out_valid}, 32'd0);

        // clr during DONE
        @(posedge clk); #1 bus.out_ready = 1'b0;
        issue(1'b0, 1'b0, 32'h00000001, 32'h00000002, 1'b0);
        wait_valid(1'b0, 4, "clr_done_latency");
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_done_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("clr_done_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("clr_done_s", bus.s, 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("clr_done_no_result", {31'b0, bus.out_valid}, 32'd0);

        // Single-chunk instance
        op8(1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        op8(2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained32", exp_q.size(), 32'd0);
        chk("scoreboard_drained8", exp8_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous abort; returns the block to IDLE.
REQ-006 SHALL have port in_valid  input  1  operands valid.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port mode  input  1  0 = add, 1 = subtract.
REQ-009 SHALL have port A  input  WIDTH  operand A.
REQ-010 SHALL have port B  input  WIDTH  operand B.
REQ-011 SHALL have port IN_Ci  input  1  carry-in, used in add mode only.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port s  output  WIDTH  sum or difference.
REQ-015 SHALL have port C_o  output  1  carry-out; in subtract mode 1 = no borrow.
REQ-016 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-017 SHALL have port zero  output  1  s equals 0.

Function
REQ-018 The FSM SHALL have three states:
- IDLE: in_ready=1.
- RUN: chunk-serial add.
- DONE: out_valid=1.
REQ-019 Input handshake: in_valid & in_ready at a rising edge SHALL capture A, B', ci and mode, clear the chunk index to 0, and move to RUN.
- Add mode: B' = B, ci = IN_Ci.
- Subtract mode: B' = ~B, ci = 1; IN_Ci is ignored.
REQ-020 Each RUN cycle SHALL add chunk i of A and B' plus the registered carry, write the result to s[i*CHUNK +: CHUNK], register the chunk carry-out, and increment i.
REQ-021 After the edge that processes chunk N-1, the block SHALL enter DONE, so out_valid rises exactly N cycles after the accepting edge.
REQ-022 In DONE, C_o SHALL be the final carry.
REQ-023 In DONE, ovf SHALL be the carry into the MSB XOR the carry out of the MSB.
REQ-024 In DONE, zero SHALL be (s == 0).
REQ-025 In DONE, s, C_o, ovf and zero SHALL remain stable until out_ready is sampled high; the block then returns to IDLE.
REQ-026 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and operands SHALL NOT be recaptured.
REQ-027 Throughput: one operation per at least N+2 cycles; accepting on the same edge as the output handshake is not supported.
REQ-028 clr=1 SHALL take priority over every handshake: next state IDLE and all outputs cleared, with any in-flight result discarded.
REQ-029 For N=1 (CHUNK=WIDTH), the block SHALL behave as a single-cycle registered adder with out_valid one cycle after acceptance.
REQ-030 Partial s bits SHALL NOT be treated as valid while out_valid=0.

Reset
REQ-031 Assertion of rst_n=0 SHALL, asynchronously and in any state including mid-RUN, force:
- FSM to IDLE and chunk index to 0;
- s, C_o, ovf, zero and out_valid to 0;
- in_ready to 1 once the FSM is in IDLE.
REQ-032 Release of rst_n SHALL be followed by normal operation from the first clock edge after release.

Structure
REQ-033 A shared package seq_adder_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DONE);
- the mode constants MODE_ADD=0 and MODE_SUB=1.
REQ-034 A sub-module chunk_adder SHALL implement one CHUNK-wide combinational ripple-carry adder (a, b, ci -> sum, co, plus the carry into its MSB for ovf), with a single instance reused every RUN cycle.
REQ-035 The chunk index SHALL be sized $clog2(N) bits, minimum 1.

Verification (WIDTH=32, CHUNK=8 unless noted)
REQ-036 Add 0xFFFFFFFF + 0x00000001, IN_Ci=0 -> out_valid exactly 4 cycles after acceptance, with s=0, C_o=1, ovf=0, zero=1.
REQ-037 Subtract 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, C_o=1, ovf=1, zero=0; also 5 - 7 -> s=0xFFFFFFFE, C_o=0, ovf=0.
REQ-038 Hold out_ready=0 for 3 cycles in DONE and toggle in_valid/A/B -> outputs unchanged and in_ready=0; then out_ready=1 -> IDLE next cycle with in_ready=1.
REQ-039 Assert rst_n=0 mid-RUN (after chunk 1) -> all outputs 0 immediately; after release, a new add of 0x12345678 + 0x11111111 -> s=0x23456789.
REQ-040 Assert clr in RUN and separately in DONE -> IDLE next cycle with out_valid=0 and no result delivered.
REQ-041 With WIDTH=8, CHUNK=8, add 0x7F + 0x01 -> out_valid 1 cycle after acceptance, with s=0x80, ovf=1, C_o=0.
